// File: rtl/mesh_port_arbiter_if.sv
// Output-port bundle for one mesh router port: requester side (req/data_in/pop_out)
// and downstream side (data_out/pndng_out/popin), plus configuration mask.
interface mesh_port_arbiter_if #(
    parameter int N_REQ   = 5,
    parameter int pckg_sz = 40,
    parameter int IDW     = $clog2(N_REQ)
);
    // Handshake: a requester offers its head packet by holding req[i]; it drops that
    // head at the rising edge where pop_out[i]=1. Downstream sees a packet while
    // pndng_out=1 and consumes it by asserting popin at a rising edge.
    logic [N_REQ-1:0]         req;
    logic [N_REQ*pckg_sz-1:0] data_in;
    logic [N_REQ-1:0]         req_mask;
    logic [N_REQ-1:0]         pop_out;
    logic [pckg_sz-1:0]       data_out;
    logic                     pndng_out;
    logic [IDW-1:0]           grant_id;
    logic                     popin;

    modport master (
        output req, data_in, req_mask, popin,
        input  pop_out, data_out, pndng_out, grant_id
    );

    modport slave (
        input  req, data_in, req_mask, popin,
        output pop_out, data_out, pndng_out, grant_id
    );
endinterface

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter plus one-entry output register for a single mesh output port.
// Grants pop the winner's FIFO combinationally; the packet lands in data_out next edge.
module mesh_port_arbiter #(
    parameter int N_REQ   = 5,
    parameter int pckg_sz = 40,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    mesh_port_arbiter_if.slave bus,
    output logic               state_dbg
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic               pndng_q;
    logic [pckg_sz-1:0] data_q;
    logic [IDW-1:0]     grant_id_q;
    logic [IDW-1:0]     ptr;

    logic [N_REQ-1:0]   ereq;
    logic               free;
    logic               grant;
    logic [IDW-1:0]     grant_idx;
    logic [IDW:0]       cand;
    logic [IDW-1:0]     next_ptr;
    logic [N_REQ-1:0]   pop_c;
    logic [pckg_sz-1:0] pkt [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pkt[i] = bus.data_in[i*pckg_sz +: pckg_sz];
        end
    end

    // Search ptr, ptr+1, ... with wrap; the first enabled requester wins.
    always_comb begin
        ereq      = bus.req & bus.req_mask;
        free      = !pndng_q || bus.popin;
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!grant && ereq[cand[IDW-1:0]]) begin
                grant     = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
        // Reset gating keeps FIFOs untouched while the port is held in reset.
        grant = grant && free && reset;
    end

    always_comb begin
        pop_c    = '0;
        next_ptr = '0;
        if (grant) begin
            pop_c = N_REQ'(1) << grant_idx;
        end
        if (grant_idx != IDW'(N_REQ-1)) begin
            next_ptr = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            pndng_q    <= 1'b0;
            data_q     <= '0;
            grant_id_q <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (grant) begin
                        state      <= FULL;
                        pndng_q    <= 1'b1;
                        data_q     <= pkt[grant_idx];
                        grant_id_q <= grant_idx;
                        ptr        <= next_ptr;
                    end
                end
                FULL: begin
                    if (grant) begin
                        data_q     <= pkt[grant_idx];
                        grant_id_q <= grant_idx;
                        ptr        <= next_ptr;
                    end else if (bus.popin) begin
                        // data_q keeps its stale value; it is meaningless while empty.
                        state   <= EMPTY;
                        pndng_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    pndng_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pop_out   = pop_c;
    assign bus.data_out  = data_q;
    assign bus.pndng_out = pndng_q;
    assign bus.grant_id  = grant_id_q;
    assign state_dbg     = (state == FULL);

endmodule

// File: doc/mesh_port_arbiter.md
# mesh_port_arbiter

Round-robin arbiter and output stage for one output port of a mesh router node. Up to `N_REQ` requesters compete for the port: the four neighbour input FIFOs and the local terminal. Each requester's routing logic has already decided that its head packet targets this port. The arbiter picks one requester, pops its FIFO, and holds the packet in a one-entry output register. It presents that register to the downstream node with the same `pndng`/`pop` handshake the mesh uses at its terminals.

## Interface
- `N_REQ`, default 5: number of requesters (index 0..N_REQ-1). Order: N, S, E, W, local.
- `pckg_sz`, default 40: packet width in bits. Packets are passed opaque and are never decoded.
- `IDW`, default `$clog2(N_REQ)`: width of the grant index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low. 0 = in reset.
- `req`, in, N_REQ: requester i has a valid head packet destined to this port.
- `data_in`, in, N_REQ*pckg_sz: head packets. Requester i occupies bits [i*pckg_sz +: pckg_sz].
- `req_mask`, in, N_REQ: configuration; 1 = requester enabled. Must only change while `req`&`req_mask` is all-zero.
- `pop_out`, out, N_REQ: one-hot pop to the granted requester's FIFO. Combinational.
- `data_out`, out, pckg_sz: held packet, registered.
- `pndng_out`, out, 1: `data_out` is valid, registered.
- `grant_id`, out, IDW: index of the requester whose packet is held, registered.
- `popin`, in, 1: downstream consumes `data_out` at this rising edge.

## Operation
- Reset values: `data_out`=0, `pndng_out`=0, `grant_id`=0, internal priority pointer `ptr`=0.
- While reset is asserted, `pop_out` is 0 regardless of `req`.
- Effective requests: `ereq = req & req_mask`.
- Free condition: `free = !pndng_out || popin`.
- Grant rule: when `free` and `ereq` != 0, `pop_out` is one-hot at the first set bit of `ereq` searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (wrap modulo N_REQ). In all other cases `pop_out` = 0.
- State machine (equivalent to `pndng_out`):
  - EMPTY, `pndng_out`=0:
    - grant → FULL.
    - no grant → stay EMPTY.
    - `popin` in EMPTY is ignored.
  - FULL, `pndng_out`=1, no `popin`: stay FULL. `data_out`/`grant_id` hold and `pop_out`=0.
  - FULL with `popin`:
    - grant in the same cycle → stay FULL, loaded with the new packet.
    - no grant → EMPTY.
- On each grant to index g, at the clock edge:
  - `data_out` ← `data_in[g]`.
  - `grant_id` ← g.
  - `ptr` ← (g+1) mod N_REQ.
- `ptr` changes only on a grant.
- On transition to EMPTY, `data_out` keeps its last value (don't-care while `pndng_out`=0).
- Fairness: with all requesters continuously active and `popin` tied high, each requester is granted exactly once per N_REQ consecutive grants.
- Masked requesters are never granted and never popped, even when they hold the pointer position.

## Timing
- Request-to-pop latency is zero: `pop_out` asserts in the same cycle `req` is seen, provided `free`.
- Pop-to-valid latency is one cycle: `pndng_out` rises at the edge that ends the grant cycle.
- Throughput: one packet per cycle when `popin` is held high with continuous requests.
- Downstream must only assert `popin` when `pndng_out`=1. Upstream FIFOs must drop the head on the `pop_out` edge.
- Combinational paths: `req` and `popin` to `pop_out`. No combinational path from any input to `data_out`/`pndng_out`.
- Asynchronous reset mid-packet:
  - Registers clear immediately.
  - The held packet is lost.
  - The first grant after release starts from index 0.

## Test plan
- **Reset values:** assert `reset`=0 with `req`=5'b11111 → `pop_out`=0, `pndng_out`=0, `data_out`=0. Release reset with `req`=0 → all outputs stay 0.
- **Single request:**
  - Stimulus: `req`=5'b00100, `data_in[2]`=40'hA5, `popin`=0.
  - Grant cycle: `pop_out`=5'b00100 for that one cycle only.
  - Next cycle: `pndng_out`=1, `data_out`=40'hA5, `grant_id`=2.
  - Hold: with `popin` still 0, `pop_out` stays 0 and outputs are stable for ≥10 cycles.
- **Round-robin, full throughput:** `req`=5'b11111, `popin`=1 from the first valid cycle → `grant_id` sequence 0,1,2,3,4,0,1 on consecutive cycles, with no bubble.
- **Pointer wrap plus mask:** `req_mask`=5'b10110, all `req` high → grants cycle 1,2,4,1,2,4. Requesters 0 and 3 are never popped.
- **Back-to-back handoff:**
  - Stimulus: FULL holding requester 3; assert `popin` and `req`=5'b00011 in the same cycle.
  - Required: `pop_out`=5'b00001 that cycle, and `grant_id`=0 next cycle.
  - Stray pop: `popin` pulsed while EMPTY has no effect.
- **Reset mid-operation:** drive `reset` low between clock edges while FULL → `pndng_out` drops before the next edge. After release, `req`=5'b10000 is granted first (index 4), and `req`=5'b11111 is granted index 0.
